obstacle_collision: RTL and testbench

OBSTACLE_COLLISION -- requirements
Module: obstacle_collision

---
 rtl/obstacle_collision.sv | 162 ++++++++++++++++
 tb/tb_obstacle_collision.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_collision.sv
// Dino-game obstacle collision detector, run/over control FSM and obstacle score counter.
// Optional macro SCORE_BCD_EN: score counts in 4 BCD digits (saturates at 9999) instead of binary (65535).
`timescale 1ns/1ps
module obstacle_collision #(
  parameter int CONV       = 0,
  parameter int DINO_X     = 40,
  parameter int DINO_W     = 16,
  parameter int DINO_H     = 20,
  parameter int HIT_FRAMES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            start,
  input  logic [9:CONV]   obstacle1_pos,
  input  logic [9:CONV]   obstacle2_pos,
  input  logic [2:0]      obstacle1_type,
  input  logic [2:0]      obstacle2_type,
  input  logic [5:0]      dino_y,
  output logic            game_over,
  output logic            hit_pulse,
  output logic            running,
  output logic [15:0]     score
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_CONFIRM = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

  localparam logic [10:0] DX_LO = 11'(DINO_X);
  localparam logic [10:0] DX_HI = 11'(DINO_X + DINO_W);
  localparam logic [10:0] DH    = 11'(DINO_H);
  localparam logic [3:0]  HIT_N = 4'(HIT_FRAMES);

  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        clr_score;
  logic        hit_p0;
  logic        act1_p1, act2_p1;
  logic        clr1_p0, clr2_p0;
  logic [1:0]  n_clear_p0;

  function automatic logic obs_hit(input logic [9:CONV] pos, input logic [2:0] typ,
                                   input logic [5:0] y);
    logic [10:0] px, w, y_ext;
    logic        h_ov, v_ov;
    px    = 11'(pos) << CONV;
    w     = (typ[2:1] == 2'b11) ? 11'd16 : (typ[2] ? 11'd12 : 11'd8);
    y_ext = 11'(y);
    h_ov  = (pos != '0) && (px < DX_HI) && ((px + w) > DX_LO);
    if (typ[2:1] == 2'b11)
      v_ov = (y_ext < 11'd28) && ((y_ext + DH) > 11'd16);
    else
      v_ov = y_ext < (typ[2] ? 11'd24 : 11'd16);
    return h_ov && v_ov;
  endfunction

`ifdef SCORE_BCD_EN
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] score_add(input logic [15:0] s, input logic [1:0] n);
    logic [15:0] r;
    r = s;
    if (n != 2'd0) r = bcd_inc(r);
    if (n == 2'd2) r = bcd_inc(r);
    return r;
  endfunction
`else
  function automatic logic [15:0] score_add(input logic [15:0] s, input logic [1:0] n);
    logic [16:0] sum;
    sum = {1'b0, s} + 17'(n);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction
`endif

  // Stage p0: combinational hit and clear detection from current inputs
  assign hit_p0     = obs_hit(obstacle1_pos, obstacle1_type, dino_y) ||
                      obs_hit(obstacle2_pos, obstacle2_type, dino_y);
  assign clr1_p0    = act1_p1 && (obstacle1_pos == '0);
  assign clr2_p0    = act2_p1 && (obstacle2_pos == '0);
  assign n_clear_p0 = {1'b0, clr1_p0} + {1'b0, clr2_p0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_score = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = 4'd0;
          clr_score = 1'b1;
        end
      end
      S_RUN: begin
        if (frame_tick && hit_p0) begin
          cnt_nxt   = 4'd1;
          state_nxt = (HIT_N == 4'd1) ? S_OVER : S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (frame_tick) begin
          if (hit_p0) begin
            cnt_nxt = cnt + 4'd1;
            if ((cnt + 4'd1) == HIT_N) state_nxt = S_OVER;
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = S_RUN;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: registered state, outputs, obstacle activity flags and score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      game_over <= 1'b0;
      hit_pulse <= 1'b0;
      running   <= 1'b0;
      act1_p1   <= 1'b0;
      act2_p1   <= 1'b0;
      score     <= 16'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      game_over <= (state_nxt == S_OVER);
      hit_pulse <= (state_nxt == S_OVER) && (state != S_OVER);
      running   <= (state_nxt == S_RUN) || (state_nxt == S_CONFIRM);
      act1_p1   <= (obstacle1_pos != '0);
      act2_p1   <= (obstacle2_pos != '0);
      // Clears on the edge that enters OVER still score
      if (clr_score)
        score <= 16'd0;
      else if ((state == S_RUN) || (state == S_CONFIRM))
        score <= score_add(score, n_clear_p0);
    end
  end

endmodule

// File: tb/tb_obstacle_collision.sv
// Self-checking bench for obstacle_collision: geometry vector table, directed corner sequences,
// and a randomized run against a behavioural model of the game rules.
`timescale 1ns/1ps
module tb_obstacle_collision;

  localparam int CONV = 0, DX = 40, DW = 16, DH = 20, HF = 2;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start;
  logic [9:0]  p1, p2;
  logic [2:0]  t1, t2;
  logic [5:0]  dy;
  logic        game_over, hit_pulse, running;
  logic [15:0] score;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  obstacle_collision #(.CONV(CONV), .DINO_X(DX), .DINO_W(DW), .DINO_H(DH), .HIT_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .obstacle1_pos(p1), .obstacle2_pos(p2), .obstacle1_type(t1), .obstacle2_type(t2),
    .dino_y(dy), .game_over(game_over), .hit_pulse(hit_pulse), .running(running), .score(score)
  );

  typedef struct {
    logic [9:0] p1;
    logic [2:0] t1;
    logic [9:0] p2;
    logic [2:0] t2;
    logic [5:0] y;
    logic       exp_hit;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obs(input int a, input int ta, input int b, input int tb, input int y);
    p1 = 10'(a); t1 = 3'(ta); p2 = 10'(b); t2 = 3'(tb); dy = 6'(y);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
    set_obs(0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Both obstacles appear then disappear together: +2 clears
  task automatic clear_pair();
    p1 = 10'd200; p2 = 10'd300;
    step();
    p1 = 10'd0; p2 = 10'd0;
    step();
  endtask

  function automatic bit ref_hit(input int pos, input int typ, input int y);
    int w, lo, hi, px;
    if (pos == 0) return 1'b0;
    px = pos << CONV;
    if (typ < 4) begin w = 8; lo = 0; hi = 16; end
    else if (typ < 6) begin w = 12; lo = 0; hi = 24; end
    else begin w = 16; lo = 16; hi = 28; end
    return (px < DX + DW) && (px + w > DX) && (y < hi) && (y + DH > lo);
  endfunction

  function automatic logic [15:0] exp_score(input int c);
`ifdef SCORE_BCD_EN
    int v;
    v = (c > 9999) ? 9999 : c;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
    return (c > 65535) ? 16'hFFFF : 16'(c);
`endif
  endfunction

  initial begin
    vecs[0]  = '{10'd44,   3'd0, 10'd0,  3'd0, 6'd0,  1'b1};
    vecs[1]  = '{10'd44,   3'd0, 10'd0,  3'd0, 6'd16, 1'b0};
    vecs[2]  = '{10'd40,   3'd6, 10'd0,  3'd0, 6'd0,  1'b1};
    vecs[3]  = '{10'd40,   3'd6, 10'd0,  3'd0, 6'd28, 1'b0};
    vecs[4]  = '{10'd56,   3'd0, 10'd0,  3'd0, 6'd0,  1'b0};
    vecs[5]  = '{10'd32,   3'd0, 10'd0,  3'd0, 6'd0,  1'b0};
    vecs[6]  = '{10'd33,   3'd1, 10'd0,  3'd0, 6'd0,  1'b1};
    vecs[7]  = '{10'd29,   3'd4, 10'd0,  3'd0, 6'd23, 1'b1};
    vecs[8]  = '{10'd29,   3'd5, 10'd0,  3'd0, 6'd24, 1'b0};
    vecs[9]  = '{10'd0,    3'd0, 10'd0,  3'd0, 6'd0,  1'b0};
    vecs[10] = '{10'd0,    3'd0, 10'd55, 3'd7, 6'd27, 1'b1};
    vecs[11] = '{10'd0,    3'd0, 10'd50, 3'd7, 6'd63, 1'b0};
    vecs[12] = '{10'd100,  3'd0, 10'd25, 3'd6, 6'd5,  1'b1};
    vecs[13] = '{10'd1000, 3'd5, 10'd0,  3'd0, 6'd0,  1'b0};

    rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
    set_obs(0, 0, 0, 0, 0);
    #1;
    chk("reset_game_over", 32'(game_over), 0);
    chk("reset_running",   32'(running),   0);
    chk("reset_hit_pulse", 32'(hit_pulse), 0);
    chk("reset_score",     32'(score),     0);
    step();
    rst = 1'b0;

    // Geometry table: two hitting frame ticks end the game only for overlapping setups
    for (int i = 0; i < 14; i++) begin
      do_reset();
      do_start();
      chk($sformatf("vec%0d_running_after_start", i), 32'(running), 1);
      set_obs(vecs[i].p1, vecs[i].t1, vecs[i].p2, vecs[i].t2, vecs[i].y);
      frame_tick = 1'b1;
      step();
      step();
      frame_tick = 1'b0;
      chk($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_hit_pulse", i), 32'(hit_pulse), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_running", i),   32'(running),   32'(!vecs[i].exp_hit));
      step();
      chk($sformatf("vec%0d_hit_pulse_drop", i), 32'(hit_pulse), 0);
      chk($sformatf("vec%0d_game_over_hold", i), 32'(game_over), 32'(vecs[i].exp_hit));
    end

    // Jumping over a cactus for ten frames
    do_reset();
    do_start();
    set_obs(44, 0, 0, 0, 16);
    frame_tick = 1'b1;
    repeat (10) step();
    frame_tick = 1'b0;
    chk("jump_game_over", 32'(game_over), 0);
    chk("jump_running",   32'(running),   1);

    // One overlapping frame, a clear frame, then one more overlap: streak restarts
    do_reset();
    do_start();
    set_obs(44, 0, 0, 0, 0);
    frame_tick = 1'b1;
    step();
    chk("confirm_running", 32'(running), 1);
    dy = 6'd16;
    step();
    dy = 6'd0;
    step();
    frame_tick = 1'b0;
    chk("streak_reset_no_over", 32'(game_over), 0);
    chk("streak_reset_running", 32'(running),   1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("streak_second_hit_over", 32'(game_over), 1);

    // Overlap without frame ticks is ignored
    do_reset();
    do_start();
    set_obs(44, 0, 0, 0, 0);
    repeat (5) step();
    chk("no_tick_no_over", 32'(game_over), 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (3) step();
    chk("tick_gap_still_running", 32'(running), 1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("tick_gap_then_over", 32'(game_over), 1);

    // Two simultaneous clears, then a single one
    do_reset();
    do_start();
    clear_pair();
    chk("double_clear_score", 32'(score), 2);
    p1 = 10'd200; step(); p1 = 10'd0; step();
    chk("single_clear_score", 32'(score), 3);

    // Clear coinciding with the game-ending tick still scores; none counted in OVER
    do_reset();
    do_start();
    set_obs(44, 0, 300, 0, 0);
    frame_tick = 1'b1;
    step();
    p2 = 10'd0;
    step();
    frame_tick = 1'b0;
    chk("coincident_over",  32'(game_over), 1);
    chk("coincident_score", 32'(score),     1);
    p1 = 10'd0;
    step();
    chk("over_no_count_score", 32'(score), 1);
    do_start();
    chk("restart_score",   32'(score),   0);
    chk("restart_running", 32'(running), 1);

    // Asynchronous reset mid-cycle while confirming
    do_reset();
    do_start();
    clear_pair();
    set_obs(44, 0, 0, 0, 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("pre_reset_score", 32'(score), 2);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_game_over", 32'(game_over), 0);
    chk("async_rst_running",   32'(running),   0);
    chk("async_rst_hit_pulse", 32'(hit_pulse), 0);
    chk("async_rst_score",     32'(score),     0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'(running), 0);
    do_start();
    chk("post_reset_start_running", 32'(running), 1);
    chk("post_reset_start_score",   32'(score),   0);

`ifdef SCORE_BCD_EN
    do_reset();
    do_start();
    repeat (4999) clear_pair();
    chk("bcd_score_9998", 32'(score), 32'h9998);
    clear_pair();
    chk("bcd_score_sat", 32'(score), 32'h9999);
    clear_pair();
    chk("bcd_score_hold", 32'(score), 32'h9999);
`else
    do_reset();
    do_start();
    repeat (300) clear_pair();
    chk("bin_score_600", 32'(score), 600);
`endif

    // Randomized run against the rule-level model
    do_reset();
    begin
      bit playing, over, was_over, h;
      bit a1, a2;
      int streak, cleared, nclr;
      playing = 0; over = 0; streak = 0; cleared = 0; a1 = 0; a2 = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        start      = ($urandom_range(0, 19) == 0);
        frame_tick = ($urandom_range(0, 2) == 0);
        p1 = ($urandom_range(0, 9) < 4) ? 10'd0 : 10'($urandom_range(20, 70));
        p2 = ($urandom_range(0, 9) < 4) ? 10'd0 : 10'($urandom_range(20, 900));
        t1 = 3'($urandom_range(0, 7));
        t2 = 3'($urandom_range(0, 7));
        dy = 6'($urandom_range(0, 40));
        h    = ref_hit(int'(p1), int'(t1), int'(dy)) || ref_hit(int'(p2), int'(t2), int'(dy));
        nclr = ((a1 && p1 == 0) ? 1 : 0) + ((a2 && p2 == 0) ? 1 : 0);
        was_over = over;
        if (!playing) begin
          if (start) begin
            playing = 1; over = 0; streak = 0; cleared = 0;
          end
        end else begin
          cleared += nclr;
          if (frame_tick) begin
            streak = h ? streak + 1 : 0;
            if (streak >= HF) begin
              playing = 0; over = 1;
            end
          end
        end
        a1 = (p1 != 0);
        a2 = (p2 != 0);
        step();
        chk($sformatf("rand%0d_game_over", cyc), 32'(game_over), 32'(over));
        chk($sformatf("rand%0d_running", cyc),   32'(running),   32'(playing));
        chk($sformatf("rand%0d_hit_pulse", cyc), 32'(hit_pulse), 32'(over && !was_over));
        chk($sformatf("rand%0d_score", cyc),     32'(score),     32'(exp_score(cleared)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
